// File: rtl/vga_frame_pkg.sv
// Shared constants and types for the camera frame-buffer VGA read side.
package vga_frame_pkg;
  // 640x480@60 Hz timing (pixel clock 25 MHz)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_ADDR_W   = 19;
  localparam int VGA_DATA_W   = 8;

  localparam int FRAME_PIXELS = VGA_H_ACTIVE * VGA_V_ACTIVE;  // 307200
  localparam int LAST_ADDR    = FRAME_PIXELS - 1;             // 307199

  typedef enum logic {
    WAIT = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and stage-0 timing decode.
// Counters sit at zero while i_en is low, so the first enabled cycle is h=0, v=0.
module vga_timing_gen
  import vga_frame_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk_i,
  input  logic rst,
  input  logic i_en,
  output logic o_visible,
  output logic o_hsync_n,
  output logic o_vsync_n,
  output logic o_line_end,
  output logic o_frame_end
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_hs_win;
  logic          w_vs_win;

  assign o_line_end  = i_en && (r_h_cnt == HW'(H_TOTAL - 1));
  assign o_frame_end = o_line_end && (r_v_cnt == VW'(V_TOTAL - 1));

  // Free-running raster counters; v advances on each line wrap
  always_ff @(posedge clk_i) begin
    if (rst || !i_en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (o_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= o_frame_end ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign w_hs_win = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                    (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_win = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                    (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));

  assign o_visible = i_en && (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign o_hsync_n = !(i_en && w_hs_win);
  assign o_vsync_n = !(i_en && w_vs_win);
endmodule

// File: rtl/vga_frame_reader.sv
// Frame-buffer scan-out: waits for a complete captured frame, then reads the
// buffer in raster order and drives VGA with the read latency absorbed.
module vga_frame_reader
  import vga_frame_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int ADDR_W   = VGA_ADDR_W,
  parameter int DATA_W   = VGA_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              frame_ready_i,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic              ram_re_o,
  input  logic [DATA_W-1:0] ram_dat_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output logic [DATA_W-1:0] rgb_o,
  output logic              frame_done_o,
  output logic              scanning_o
);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t            r_state;
  logic              r_scanning;
  logic [ADDR_W-1:0] r_addr;     // address of the next visible pixel
  logic [ADDR_W-1:0] r_adr_q;    // last driven address, held through blanking
  logic              r_hsync;
  logic              r_vsync;
  logic              r_de;
  logic [1:0]        r_done_pipe; // last-pixel marker: issue -> output -> done
  logic              w_en;
  logic              w_visible;
  logic              w_hsync_n;
  logic              w_vsync_n;
  logic              w_line_end;
  logic              w_frame_end;

  assign w_en = (r_state == SCAN);

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i      (clk_i),
    .rst        (rst),
    .i_en       (w_en),
    .o_visible  (w_visible),
    .o_hsync_n  (w_hsync_n),
    .o_vsync_n  (w_vsync_n),
    .o_line_end (w_line_end),
    .o_frame_end(w_frame_end)
  );

  // Control FSM: arm on the first ready frame, then scan until reset
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state    <= WAIT;
      r_scanning <= 1'b0;
    end else begin
      case (r_state)
        WAIT: if (frame_ready_i) begin
          r_state    <= SCAN;
          r_scanning <= 1'b1;
        end
        SCAN: begin
          r_state    <= SCAN;
          r_scanning <= 1'b1;
        end
        default: begin
          r_state    <= WAIT;
          r_scanning <= 1'b0;
        end
      endcase
    end
  end

  // Raster address: +1 per visible pixel, saturates at the last pixel, rewinds at frame end
  always_ff @(posedge clk_i) begin
    if (rst || !w_en) begin
      r_addr  <= '0;
      r_adr_q <= '0;
    end else begin
      r_adr_q <= ram_adr_o;
      if (w_frame_end)
        r_addr <= '0;
      else if (w_visible && (r_addr != LAST_PIX))
        r_addr <= r_addr + ADDR_W'(1);
    end
  end

  assign ram_re_o  = w_visible;
  assign ram_adr_o = w_visible ? r_addr : r_adr_q;

  // Output stage: delay timing one cycle to line up with the buffer read data
  always_ff @(posedge clk_i) begin
    if (rst || !w_en) begin
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_de        <= 1'b0;
      r_done_pipe <= '0;
    end else begin
      r_hsync     <= w_hsync_n;
      r_vsync     <= w_vsync_n;
      r_de        <= w_visible;
      r_done_pipe <= {r_done_pipe[0], w_visible && (r_addr == LAST_PIX)};
    end
  end

  assign hsync_o      = r_hsync;
  assign vsync_o      = r_vsync;
  assign de_o         = r_de;
  assign rgb_o        = r_de ? ram_dat_i : '0;
  assign frame_done_o = r_done_pipe[1];
  assign scanning_o   = r_scanning;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full 800-cycle line timing, frame height shrunk
// to 8 visible lines (15 total) so several frames fit in a short run.
module tb_vga_frame_reader;
  localparam int HA = 640, HT = 800, VA = 8, VT = 15;
  localparam int FT = HT * VT;
  localparam int LAST = HA * VA - 1;
  localparam int HS0 = 656, HS1 = 752, VS0 = 10, VS1 = 12;
  localparam logic [32:0] RESET_V = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 19'h0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fr  = 1'b0;
  logic [18:0] adr;
  logic        re;
  logic [7:0]  dat = 8'h00;
  logic        hs, vs, de, done, scan;
  logic [7:0]  rgb;
  logic [32:0] obs;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  logic [7:0] sb_q[$];

  vga_frame_reader #(
    .V_ACTIVE(VA), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk_i        (clk),
    .rst          (rst),
    .frame_ready_i(fr),
    .ram_adr_o    (adr),
    .ram_re_o     (re),
    .ram_dat_i    (dat),
    .hsync_o      (hs),
    .vsync_o      (vs),
    .de_o         (de),
    .rgb_o        (rgb),
    .frame_done_o (done),
    .scanning_o   (scan)
  );

  always #20 clk = ~clk;

  // Buffer model: one-cycle read latency, data = addr[7:0], junk when not read
  always @(posedge clk) dat <= re ? adr[7:0] : 8'($urandom_range(255));

  assign obs = {hs, vs, de, re, rgb, adr, done, scan};

  // Reference model of the raster, indexed by cycles since the first SCAN cycle
  function automatic bit vis(int tt);
    int f;
    if (tt < 0) return 1'b0;
    f = tt % FT;
    return ((f % HT) < HA) && ((f / HT) < VA);
  endfunction

  function automatic int eadr(int tt);
    int f, h, v;
    if (tt < 0) return 0;
    f = tt % FT; h = f % HT; v = f / HT;
    if (v >= VA) return LAST;
    if (h < HA) return v * HA + h;
    return v * HA + HA - 1;
  endfunction

  function automatic bit ehs(int tt);
    int h;
    if (tt < 0) return 1'b1;
    h = (tt % FT) % HT;
    return !(h >= HS0 && h < HS1);
  endfunction

  function automatic bit evs(int tt);
    int v;
    if (tt < 0) return 1'b1;
    v = (tt % FT) / HT;
    return !(v >= VS0 && v < VS1);
  endfunction

  function automatic logic [32:0] expv(int tt);
    bit d;
    d = vis(tt - 1);
    return {ehs(tt - 1), evs(tt - 1), d, vis(tt),
            d ? 8'(eadr(tt - 1)) : 8'h00, 19'(eadr(tt)),
            (tt >= 2) && (((tt - 2) % FT) == (VA - 1) * HT + HA - 1), 1'b1};
  endfunction

  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic test_reset();
    rst = 1'b1; fr = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== RESET_V) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=%h", obs, RESET_V);
    end
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== RESET_V) begin
        miscompares++;
        $display("FAIL wait_idle cyc=%0d got=%h want=%h", i, obs, RESET_V);
      end
    end
  endtask

  task automatic test_first_line();
    fr = 1'b1;
    t = -1;
    for (int i = 0; i <= HT; i++) begin
      tick();
      vectors++;
      if (obs !== expv(t)) begin
        miscompares++;
        $display("FAIL first_line t=%0d got=%h want=%h", t, obs, expv(t));
      end
      if (t == 0) begin
        vectors++;
        if ({re, adr} !== {1'b1, 19'd0}) begin
          miscompares++;
          $display("FAIL first_read got re=%b adr=%0d want re=1 adr=0", re, adr);
        end
      end
      if (t == 1) begin
        vectors++;
        if ({de, rgb} !== {1'b1, 8'h00}) begin
          miscompares++;
          $display("FAIL first_pixel got de=%b rgb=%h want de=1 rgb=00", de, rgb);
        end
      end
      if (t == HA) begin
        vectors++;
        if ({de, rgb} !== {1'b1, 8'h7F}) begin
          miscompares++;
          $display("FAIL line0_last got de=%b rgb=%h want de=1 rgb=7f", de, rgb);
        end
      end
      if (t == HT) begin
        vectors++;
        if ({re, adr} !== {1'b1, 19'd640}) begin
          miscompares++;
          $display("FAIL line1_start got re=%b adr=%0d want re=1 adr=640", re, adr);
        end
      end
    end
  endtask

  task automatic test_horizontal();
    int de_rise = -100000, de_fall = -100000, hs_fall = -100000, n_lines = 0;
    logic p_de, p_hs;
    p_de = de; p_hs = hs;
    for (int i = 0; i < 3 * HT; i++) begin
      tick();
      if (de && !p_de) de_rise = t;
      if (!de && p_de) begin
        vectors++;
        if (t - de_rise != HA) begin
          miscompares++;
          $display("FAIL de_width got=%0d want=%0d", t - de_rise, HA);
        end
        de_fall = t;
      end
      if (!hs && p_hs) begin
        vectors++;
        if (t - de_fall != 16) begin
          miscompares++;
          $display("FAIL hsync_gap got=%0d want=16", t - de_fall);
        end
        if (hs_fall > 0) begin
          vectors++;
          if (t - hs_fall != HT) begin
            miscompares++;
            $display("FAIL line_period got=%0d want=%0d", t - hs_fall, HT);
          end
        end
        hs_fall = t;
        n_lines++;
      end
      if (hs && !p_hs) begin
        vectors++;
        if (t - hs_fall != 96) begin
          miscompares++;
          $display("FAIL hsync_width got=%0d want=96", t - hs_fall);
        end
      end
      p_de = de; p_hs = hs;
    end
    vectors++;
    if (n_lines != 3) begin
      miscompares++;
      $display("FAIL hsync_count got=%0d want=3", n_lines);
    end
  endtask

  task automatic test_full_frame();
    int vs_low = 0, n_done = 0, last_adr = -1, restart = -1;
    while (t < FT + HT) begin
      tick();
      vectors++;
      if (obs !== expv(t)) begin
        miscompares++;
        $display("FAIL frame_model t=%0d got=%h want=%h", t, obs, expv(t));
      end
      if (!vs) vs_low++;
      if (done) n_done++;
      if (re && t < FT) last_adr = int'(adr);
      if (re && adr == 19'd0 && t >= FT && restart < 0) restart = t;
      if (t == 5000) fr = 1'b0;
    end
    vectors++;
    if (vs_low != 1600) begin
      miscompares++;
      $display("FAIL vsync_width got=%0d want=1600", vs_low);
    end
    vectors++;
    if (last_adr != LAST) begin
      miscompares++;
      $display("FAIL last_addr got=%0d want=%0d", last_adr, LAST);
    end
    vectors++;
    if (n_done != 1) begin
      miscompares++;
      $display("FAIL frame_done_count got=%0d want=1", n_done);
    end
    vectors++;
    if (restart != FT) begin
      miscompares++;
      $display("FAIL frame_period got=%0d want=%0d", restart, FT);
    end
    vectors++;
    if (scan !== 1'b1) begin
      miscompares++;
      $display("FAIL scan_after_drop got=%b want=1", scan);
    end
  endtask

  task automatic test_rgb_scoreboard();
    logic p_re;
    sb_q.delete();
    if (re) sb_q.push_back(adr[7:0]);
    p_re = re;
    for (int i = 0; i < 3 * FT; i++) begin
      tick();
      vectors++;
      if (de !== p_re) begin
        miscompares++;
        $display("FAIL de_align t=%0d got de=%b want=%b", t, de, p_re);
      end
      if (de) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL rgb_underflow t=%0d got rgb=%h want queued data", t, rgb);
        end else begin
          logic [7:0] e;
          e = sb_q.pop_front();
          if (rgb !== e) begin
            miscompares++;
            $display("FAIL rgb_data t=%0d got=%h want=%h", t, rgb, e);
          end
        end
      end else begin
        vectors++;
        if (rgb !== 8'h00) begin
          miscompares++;
          $display("FAIL rgb_blank t=%0d got=%h want=00", t, rgb);
        end
      end
      if (re) sb_q.push_back(adr[7:0]);
      p_re = re;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < FT && (t % FT) != 5 * HT + 300; i++) tick();
    vectors++;
    if (obs !== expv(t)) begin
      miscompares++;
      $display("FAIL pre_reset t=%0d got=%h want=%h", t, obs, expv(t));
    end
    rst = 1'b1; fr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== RESET_V) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d got=%h want=%h", i, obs, RESET_V);
      end
    end
    rst = 1'b0;
    t = -1;
    for (int i = 0; i <= HT; i++) begin
      tick();
      vectors++;
      if (obs !== expv(t)) begin
        miscompares++;
        $display("FAIL restart t=%0d got=%h want=%h", t, obs, expv(t));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_horizontal();
    test_full_frame();
    test_rgb_scoreboard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Read side of the camera frame buffer. Waits until the capture path reports a complete 640x480 frame, then scans the buffer in raster order and drives a 640x480@60 Hz VGA output with continuous sync. It issues one read strobe and address per visible pixel, absorbs the one-cycle buffer read latency, and emits 8-bit RGB332 pixels aligned with hsync, vsync and data-enable.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- ADDR_W, 19, frame-buffer address width
- DATA_W, 8, pixel width (RGB332)
- clk_i  in  1  pixel clock, 25 MHz nominal
- rst  in  1  synchronous, active-high reset
- frame_ready_i  in  1  level; high once the capture side has written the last pixel (address 307199)
- ram_adr_o  out  ADDR_W  frame-buffer read address
- ram_re_o  out  1  read strobe; buffer returns ram_dat_i one clk_i cycle later
- ram_dat_i  in  DATA_W  read data
- hsync_o  out  1  horizontal sync, active-low
- vsync_o  out  1  vertical sync, active-low
- de_o  out  1  pixel valid (visible area)
- rgb_o  out  DATA_W  pixel value; 0 when de_o=0
- frame_done_o  out  1  one-cycle pulse after the last pixel of each frame is output
- scanning_o  out  1  high in SCAN state

## Operation
- States:
  - WAIT: counters held at 0, no reads, syncs inactive.
  - SCAN: counters free-running.
- WAIT -> SCAN on the first cycle with frame_ready_i=1. SCAN exits only on rst.
- frame_ready_i dropping during SCAN is ignored; the buffer is rescanned every frame.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt runs 0..524; it increments when h_cnt wraps, and itself wraps 524 -> 0.
- Visible area: h_cnt<640 and v_cnt<480.
- Address counter:
  - Cleared to 0 at h_cnt=0, v_cnt=0.
  - Increments by 1 after each visible pixel; range 0..307199, never exceeds 307199.
  - No multiplier.
- In each visible cycle: ram_re_o=1 and ram_adr_o = current address. Otherwise ram_re_o=0 and ram_adr_o holds its last value.
- Stage-0 timing signals (from the counters):
  - hsync active (low) when 656<=h_cnt<752.
  - vsync active (low) when 490<=v_cnt<492.
- Output stage (one register stage after stage 0):
  - hsync_o, vsync_o, de_o = stage-0 values delayed 1 cycle.
  - rgb_o = ram_dat_i when the delayed de is 1, else 0.
- frame_done_o pulses in the cycle after the output cycle whose address was 307199.
- Reset values (also forced in WAIT): hsync_o=1, vsync_o=1, de_o=0, rgb_o=0, ram_re_o=0, ram_adr_o=0, frame_done_o=0, scanning_o=0, state=WAIT, all counters 0.

## Timing
- First SCAN cycle is the cycle after frame_ready_i is sampled high.
  - In that cycle: h_cnt=0, v_cnt=0, ram_re_o=1, ram_adr_o=0.
  - One cycle later: de_o=1, rgb_o = data at address 0.
- Pipeline latency from address to pixel: 1 cycle. Sync and de are delayed equally, so all outputs stay mutually aligned.
- Line period: 800 cycles. Frame period: 420000 cycles.
- de_o is high for 640 consecutive cycles per visible line.
- hsync_o falls 657 cycles after de_o's line start reference (h_cnt 656 + 1).
- rst mid-frame: next cycle all outputs take their reset values. A scan after reset restarts at address 0; no partial-line output.
- rst and frame_ready_i high together: rst wins. SCAN begins the cycle after rst falls.

## Structure
- Package vga_frame_pkg holds:
  - 640x480@60 timing constants.
  - FRAME_PIXELS=307200, LAST_ADDR=307199.
  - The state enum {WAIT, SCAN}.
- Sub-module vga_timing_gen contains:
  - h/v counters.
  - Stage-0 visible, hsync and vsync signals.
  - line_end and frame_end strobes.
  - Enable input driven by the SCAN state.
- The top level holds the FSM, the address counter and the output register stage.

## Test plan
- Reset, frame_ready_i=0 for 2000 cycles -> hsync_o=vsync_o=1, de_o=0, ram_re_o=0, scanning_o=0 throughout.
- Raise frame_ready_i; buffer model returns data = addr[7:0] -> first de_o cycle has rgb_o=0x00. Line 0 ends with rgb_o=0x7F at address 639. Line 1 starts at address 640.
- Horizontal timing: per line, de_o high for 640 cycles, hsync_o low for exactly 96 cycles starting 16 cycles after de_o falls, period 800.
- Full frame: vsync_o low for 1600 cycles; last ram_adr_o=307199; frame_done_o pulses once. The next frame restarts at address 0, 420000 cycles after the previous start.
- Drop frame_ready_i mid-frame -> scanning continues unchanged. Assert rst at h_cnt=300, v_cnt=100 -> next cycle all outputs at reset values. Release rst with frame_ready_i=1 -> restart at address 0.
- Continuous rgb check: over 3 frames, every rgb_o equals the model data for the address issued exactly one cycle earlier; rgb_o=0 whenever de_o=0.
